// File: rtl/sp_ram_be_if.sv
// sp_ram_be_if: request/response bus of the byte-enable single-port RAM
// Signals: cs/we/be/addr/wdata (requester -> RAM), rdata/rvalid/ready (RAM -> requester),
// plus perr when SP_RAM_BE_PARITY_EN is defined.
interface sp_ram_be_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    cs;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    ready;
`ifdef SP_RAM_BE_PARITY_EN
    logic                    perr;
    modport master (output cs, we, be, addr, wdata, input rdata, rvalid, ready, perr);
    modport slave (input cs, we, be, addr, wdata, output rdata, rvalid, ready, perr);
`else
    modport master (output cs, we, be, addr, wdata, input rdata, rvalid, ready);
    modport slave (input cs, we, be, addr, wdata, output rdata, rvalid, ready);
`endif
endinterface

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port RAM with byte enables, INIT sweep after reset and 1/2-cycle read latency
// Ports: clk, rst (sync active-high), bus (sp_ram_be_if.slave: cs/we/be/addr/wdata in,
// rdata/rvalid/ready out). Macro SP_RAM_BE_PARITY_EN adds per-byte even parity and bus.perr.
module sp_ram_be #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input logic        clk,
    input logic        rst,
    sp_ram_be_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
`ifdef SP_RAM_BE_PARITY_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif
    typedef enum logic {INIT, RUN} state_e;
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    last, acc, in_range, rd_acc, wr_acc;
    logic [EW-1:0]           rd_word, s_w, rdata_q;
    logic                    s_v, rvalid_q;
`ifdef SP_RAM_BE_PARITY_EN
    logic [NB-1:0]           par_q [DEPTH];
    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
        for (int i = 0; i < NB; i++) byte_par[i] = ^d[8*i +: 8];
    endfunction
`endif
    always_comb begin
        last    = state_q == INIT && cnt_q == ADDR_WIDTH'(DEPTH - 1);
        cnt_d   = (state_q == INIT && !last) ? cnt_q + 1'b1 : '0;
        state_d = (state_q == RUN || last) ? RUN : INIT;
    end
    assign bus.ready = state_q == RUN;
    assign acc       = bus.cs & bus.ready;
    assign in_range  = int'(bus.addr) < DEPTH;
    assign rd_acc    = acc & ~bus.we;
    assign wr_acc    = acc & bus.we & in_range;
    // Out-of-range reads return zero data and, with parity, no error flag.
`ifdef SP_RAM_BE_PARITY_EN
    assign rd_word = in_range ? {|(par_q[bus.addr] ^ byte_par(mem_q[bus.addr])), mem_q[bus.addr]} : '0;
`else
    assign rd_word = in_range ? mem_q[bus.addr] : '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT) begin
            mem_q[cnt_q] <= INIT_VALUE;
`ifdef SP_RAM_BE_PARITY_EN
            par_q[cnt_q] <= byte_par(INIT_VALUE);
`endif
        end else if (!rst && wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem_q[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
`ifdef SP_RAM_BE_PARITY_EN
                    par_q[bus.addr][i] <= ^bus.wdata[8*i +: 8];
`endif
                end
            end
        end
    end
    // Latency 2 inserts one pipeline stage between the array read and the output register.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic          v_q;
            logic [EW-1:0] w_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    w_q <= '0;
                end else begin
                    v_q <= rd_acc;
                    w_q <= rd_word;
                end
            end
            assign s_v = v_q;
            assign s_w = w_q;
        end else begin : g_lat1
            assign s_v = rd_acc;
            assign s_w = rd_word;
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= s_v;
            if (s_v) rdata_q <= s_w;
        end
    end
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q[DATA_WIDTH-1:0];
`ifdef SP_RAM_BE_PARITY_EN
    assign bus.perr   = rvalid_q & rdata_q[DATA_WIDTH];
`endif
endmodule

// File: tb/tb_sp_ram_be.sv
// tb_sp_ram_be: three RAM instances (depth/latency 256/1, 256/2, 200/1) against a behavioural model
module tb_sp_ram_be;
    localparam logic [31:0] IV = 32'h5A5A_0F0F;
    logic        clk = 1'b0;
    logic        rst, cs, we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  rv, rdy;
    logic [31:0] rd [3];
    always #5 clk = ~clk;

    sp_ram_be_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
    sp_ram_be_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_b ();
    sp_ram_be_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_c ();
    sp_ram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .READ_LATENCY(1), .INIT_VALUE(IV))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    sp_ram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .READ_LATENCY(2), .INIT_VALUE(IV))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    sp_ram_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .READ_LATENCY(1), .INIT_VALUE(IV))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.cs = cs;  assign if_a.we = we;  assign if_a.be = be;  assign if_a.addr = addr;  assign if_a.wdata = wdata;
    assign if_b.cs = cs;  assign if_b.we = we;  assign if_b.be = be;  assign if_b.addr = addr;  assign if_b.wdata = wdata;
    assign if_c.cs = cs;  assign if_c.we = we;  assign if_c.be = be;  assign if_c.addr = addr;  assign if_c.wdata = wdata;
    assign rv  = {if_c.rvalid, if_b.rvalid, if_a.rvalid};
    assign rdy = {if_c.ready, if_b.ready, if_a.ready};
    assign rd[0] = if_a.rdata;
    assign rd[1] = if_b.rdata;
    assign rd[2] = if_c.rdata;
`ifdef SP_RAM_BE_PARITY_EN
    logic [2:0] pe;
    assign pe = {if_c.perr, if_b.perr, if_a.perr};
`endif

    function automatic int dep(int k);
        return k == 2 ? 200 : 256;
    endfunction
    function automatic int lat(int k);
        return k == 1 ? 2 : 1;
    endfunction

    // Model: memory image per instance, queue of pending read results keyed by due cycle.
    typedef struct {
        int          k;
        int          due;
        logic [31:0] d;
        logic        p;
    } rd_t;
    rd_t         pq[$];
    logic [31:0] mm [3][256];
    logic [31:0] ed [3];
    logic [2:0]  ev, ep;
    int          cyc = 0, rst_cyc = 0, checks = 0, errors = 0;
    bit          started = 0, flip5 = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", name, k, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1;
            rst_cyc = cyc;
            flip5   = 0;
            pq.delete();
            for (int k = 0; k < 3; k++) begin
                ev[k] = 0;
                ep[k] = 0;
                ed[k] = '0;
                for (int a = 0; a < 256; a++) mm[k][a] = IV;
            end
        end else if (started) begin
            for (int k = 0; k < 3; k++) begin
                if (cs && cyc - rst_cyc > dep(k)) begin
                    if (we) begin
                        if (int'(addr) < dep(k))
                            for (int i = 0; i < 4; i++) if (be[i]) mm[k][addr][8*i +: 8] = wdata[8*i +: 8];
                    end else begin
                        pq.push_back('{k, cyc + lat(k) - 1, int'(addr) < dep(k) ? mm[k][addr] : 32'h0,
                                       k == 0 && flip5 && addr == 8'd5});
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                ev[k] = 0;
                ep[k] = 0;
                for (int j = 0; j < pq.size(); j++) begin
                    if (pq[j].k == k && pq[j].due == cyc) begin
                        ev[k] = 1;
                        ed[k] = pq[j].d;
                        ep[k] = pq[j].p;
                        pq.delete(j);
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk("ready", k, 32'(rdy[k]), 32'(cyc - rst_cyc >= dep(k)));
                chk("rvalid", k, 32'(rv[k]), 32'(ev[k]));
                chk("rdata", k, rd[k], ed[k]);
`ifdef SP_RAM_BE_PARITY_EN
                chk("perr", k, 32'(pe[k]), 32'(ep[k]));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1; we = 1; addr = a; wdata = d; be = b;
        step();
        cs = 0; we = 0;
    endtask
    task automatic rd_req(input logic [7:0] a);
        cs = 1; we = 0; addr = a; be = 4'h0;
        step();
        cs = 0;
    endtask
    task automatic wait_ready(input string name);
        int n = 0;
        while (!rdy[0] && n < 400) begin
            step();
            n++;
        end
        chk(name, 0, n, 256);
    endtask

    initial begin
        rst = 1; cs = 0; we = 0; be = 0; addr = 0; wdata = 0;
        step();
        rst = 0;
        wait_ready("init_len");
        rd_req(8'd0);
        chk("lit_rv_a0", 0, 32'(rv[0]), 1);
        chk("lit_init_a0", 0, rd[0], IV);
        rd_req(8'd255);
        chk("lit_init_a255", 0, rd[0], IV);
        chk("lit_init_b0", 1, rd[1], IV);
        wr(8'h10, 32'hAABB_CCDD, 4'hF);
        wr(8'h10, 32'h1122_3344, 4'h5);
        rd_req(8'h10);
        chk("lit_merge_a", 0, rd[0], 32'hAA22_CC44);
        chk("lit_model_merge", 0, ed[0], 32'hAA22_CC44);
        chk("lit_lat2_early", 1, 32'(rv[1]), 0);
        step();
        chk("lit_merge_b", 1, rd[1], 32'hAA22_CC44);
        chk("lit_lat2_rv", 1, 32'(rv[1]), 1);
        chk("lit_hold_a", 0, rd[0], 32'hAA22_CC44);
        wr(8'd1, 32'h0101_0101, 4'hF);
        wr(8'd2, 32'h0202_0202, 4'hF);
        wr(8'd3, 32'h0303_0303, 4'hF);
        rd_req(8'd1);
        rd_req(8'd2);
        rd_req(8'd3);
        chk("lit_b2b_a3", 0, rd[0], 32'h0303_0303);
        chk("lit_b2b_b2", 1, rd[1], 32'h0202_0202);
        step();
        wr(8'd250, 32'hFFFF_FFFF, 4'hF);
        rd_req(8'd250);
        chk("lit_oor_rv", 2, 32'(rv[2]), 1);
        chk("lit_oor_data", 2, rd[2], 32'h0);
        chk("lit_inr_data", 0, rd[0], 32'hFFFF_FFFF);
        rd_req(8'd50);
        chk("lit_alias", 2, rd[2], IV);
        wr(8'h10, 32'h0, 4'h0);
        rd_req(8'h10);
        chk("lit_be0", 0, rd[0], 32'hAA22_CC44);
`ifdef SP_RAM_BE_PARITY_EN
        dut_a.mem_q[5][0] = ~dut_a.mem_q[5][0];
        mm[0][5][0] = ~mm[0][5][0];
        flip5 = 1;
        rd_req(8'd5);
        chk("lit_perr_bad", 0, 32'(pe[0]), 1);
        rd_req(8'd6);
        chk("lit_perr_clean", 0, 32'(pe[0]), 0);
`endif
        step();
        rd_req(8'd7);
        rst = 1; cs = 1; we = 0; addr = 8'd8;
        step();
        rst = 0;
        for (int i = 0; i < 99; i++) begin
            we = i[0]; addr = 8'h10; wdata = 32'hDEAD_BEEF; be = 4'hF;
            step();
        end
        rst = 1; we = 1;
        step();
        rst = 0;
        wait_ready("reinit_len");
        cs = 0; we = 0;
        rd_req(8'h10);
        chk("lit_reinit", 0, rd[0], IV);
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sp_ram_be.md
SP_RAM_BE -- requirements
Module: sp_ram_be

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, address bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; a multiple of 8.
REQ-003 The block SHALL have parameter DEPTH, default 256, word count; legal range 2..2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, clk edges from accepted read to rvalid; legal values 1 and 2.
REQ-005 The block SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-wide word written to every location during initialisation.
REQ-006 The block SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port cs, input, 1, request strobe.
REQ-009 The block SHALL have port we, input, 1, 1=write, 0=read; qualified by cs.
REQ-010 The block SHALL have port be, input, DATA_WIDTH/8, byte enables; bit i covers data bits [8i+7:8i].
REQ-011 The block SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-012 The block SHALL have port wdata, input, DATA_WIDTH, write data.
REQ-013 The block SHALL have port rdata, output, DATA_WIDTH, read data; separate from wdata, no tristate.
REQ-014 The block SHALL have port rvalid, output, 1, one-cycle pulse marking rdata valid.
REQ-015 The block SHALL have port ready, output, 1, high when requests are accepted.

Function
REQ-016 The block SHALL accept a request on a rising edge where cs=1 and ready=1; cs while ready=0 is ignored and produces no rvalid.
REQ-017 An accepted write SHALL update only the bytes with be=1 at addr; be=0 on all bytes is a legal no-op.
REQ-018 An accepted read SHALL drive the addr contents on rdata with rvalid=1 exactly READ_LATENCY cycles later, ignoring be.
REQ-019 Back-to-back reads SHALL sustain one per cycle; a read following a write to the same addr SHALL return the written data.
REQ-020 rdata SHALL hold its last value when rvalid=0.
REQ-021 An accepted access with addr >= DEPTH SHALL be treated as out of range: a write is dropped; a read returns all-zero with normal rvalid timing.
REQ-022 The control FSM SHALL have two states: INIT and RUN.
REQ-023 In INIT the FSM SHALL write INIT_VALUE to address 0..DEPTH-1, one word per cycle, with ready=0.
REQ-024 After address DEPTH-1 is written, the FSM SHALL enter RUN and assert ready the next cycle; INIT therefore lasts DEPTH cycles.
REQ-025 In RUN ready SHALL be 1 and the FSM SHALL remain in RUN until rst.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter INIT with sweep counter=0, ready=0, rvalid=0 and rdata=0.
REQ-027 rst asserted mid-INIT or mid-read SHALL restart the sweep from address 0 and cancel in-flight reads (no rvalid).
REQ-028 Memory contents SHALL be undefined only until INIT completes.

Configuration
REQ-029 When macro SP_RAM_BE_PARITY_EN is defined, the block SHALL store one even-parity bit per byte, add output perr (1 bit), and pulse perr with rvalid when any read byte fails the parity check.
REQ-030 When SP_RAM_BE_PARITY_EN is defined, INIT SHALL write correct parity, perr SHALL reset to 0, and an out-of-range read SHALL give perr=0.
REQ-031 Without SP_RAM_BE_PARITY_EN, no parity storage and no perr port SHALL exist; behaviour is otherwise identical.

Verification
REQ-032 Apply rst 1 cycle, then idle (DEPTH=256) -> ready=0 for 256 cycles, then ready=1; reads of addr 0 and 255 return INIT_VALUE.
REQ-033 Write addr 0x10 wdata 0xAABBCCDD be=1111, then write 0x11223344 be=0101, then read -> rdata=0xAA22CC44 with rvalid after READ_LATENCY cycles (run both 1 and 2).
REQ-034 Issue reads to addr 1,2,3 on consecutive cycles -> three consecutive rvalid pulses carrying the matching data in order.
REQ-035 Assert cs during INIT, and assert rst 100 cycles into INIT -> no rvalid, memory unchanged, and ready rises exactly 256 cycles after the rst edge.
REQ-036 With DEPTH=200, write 0xFFFFFFFF to addr 250, then read addr 250 -> rdata=0, rvalid=1; addr 250 mod 200 unchanged.
REQ-037 With SP_RAM_BE_PARITY_EN defined, force-flip one stored data bit at addr 5, then read addr 5 -> perr=1 coincident with rvalid; reading a clean address gives perr=0.
